// File: rtl/div_issue_ctrl.sv
// Issue/handshake control between EX and the iterative divider core.
// Latches operands, stalls the pipe, writes HI/LO and drains after flush.
module div_issue_ctrl #(
  parameter int DATA_W       = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                div_req,
  input  logic                div_signed_i,
  input  logic [DATA_W-1:0]   op_a_i,
  input  logic [DATA_W-1:0]   op_b_i,
  input  logic                flush,
  input  logic                div_ready_i,
  input  logic [2*DATA_W-1:0] div_result_i,
  output logic                div_start_o,
  output logic                div_annul_o,
  output logic                div_signed_o,
  output logic [DATA_W-1:0]   div_op1_o,
  output logic [DATA_W-1:0]   div_op2_o,
  output logic                stall_req,
  output logic                hilo_we,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                busy
);

  localparam int CNT_W =
    (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    DRAIN
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic              start_n;
  logic              sgn_n;
  logic [DATA_W-1:0] op1_n;
  logic [DATA_W-1:0] op2_n;
  logic [DATA_W-1:0] hi_n;
  logic [DATA_W-1:0] lo_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      div_start_o  <= 1'b0;
      div_signed_o <= 1'b0;
      div_op1_o    <= '0;
      div_op2_o    <= '0;
      hi_o         <= '0;
      lo_o         <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      div_start_o  <= start_n;
      div_signed_o <= sgn_n;
      div_op1_o    <= op1_n;
      div_op2_o    <= op2_n;
      hi_o         <= hi_n;
      lo_o         <= lo_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    start_n     = div_start_o;
    sgn_n       = div_signed_o;
    op1_n       = div_op1_o;
    op2_n       = div_op2_o;
    hi_n        = hi_o;
    lo_n        = lo_o;
    stall_req   = 1'b0;
    div_annul_o = 1'b0;
    hilo_we     = 1'b0;
    unique case (state)
      IDLE: begin
        stall_req = div_req & ~flush;
        if (div_req && !flush) begin
          op1_n   = op_a_i;
          op2_n   = op_b_i;
          sgn_n   = div_signed_i;
          start_n = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        // flush beats a same-cycle ready: the result is dropped
        if (flush) begin
          div_annul_o = 1'b1;
          start_n     = 1'b0;
          cnt_n       = DRAIN_LD;
          state_n     = DRAIN;
        end else if (div_ready_i) begin
          hi_n    = div_result_i[2*DATA_W-1:DATA_W];
          lo_n    = div_result_i[DATA_W-1:0];
          start_n = 1'b0;
          state_n = DONE;
        end
      end
      DONE: begin
        hilo_we = ~flush;
        start_n = 1'b0;
        state_n = IDLE;
      end
      DRAIN: begin
        start_n = 1'b0;
        if (cnt <= CNT_ONE) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      default: begin
        start_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with a behavioural divider core model.
// Randomised and directed divides checked against plain arithmetic.
module tb_div_issue_ctrl;

  localparam int W     = 32;
  localparam int DRAIN = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          div_req = 1'b0;
  logic          div_signed_i = 1'b0;
  logic [W-1:0]  op_a_i = '0;
  logic [W-1:0]  op_b_i = '0;
  logic          flush = 1'b0;
  logic          div_ready_i = 1'b0;
  logic [2*W-1:0] div_result_i = '0;
  logic          div_start_o;
  logic          div_annul_o;
  logic          div_signed_o;
  logic [W-1:0]  div_op1_o;
  logic [W-1:0]  div_op2_o;
  logic          stall_req;
  logic          hilo_we;
  logic [W-1:0]  hi_o;
  logic [W-1:0]  lo_o;
  logic          busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int core_cnt = 0;
  int we_cyc = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  div_issue_ctrl #(.DATA_W(W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .div_req(div_req),
    .div_signed_i(div_signed_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .flush(flush), .div_ready_i(div_ready_i),
    .div_result_i(div_result_i), .div_start_o(div_start_o),
    .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .stall_req(stall_req), .hilo_we(hilo_we),
    .hi_o(hi_o), .lo_o(lo_o), .busy(busy)
  );

  function automatic logic [2*W-1:0] ref_div(
    input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    int sa, sb;
    logic [W-1:0] q, r;
    if (b == '0) return '0;
    if (sgn) begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    return {r, q};
  endfunction

  // core: ready after 36 start cycles (4 for a zero divisor)
  always @(negedge clk) begin
    if (!div_start_o) begin
      core_cnt = 0;
      div_ready_i = 1'b0;
      div_result_i = {$urandom, $urandom};
    end else begin
      core_cnt++;
      div_ready_i = (core_cnt == ((div_op2_o == '0) ? 4 : 36));
      if (div_ready_i)
        div_result_i = ref_div(div_op1_o, div_op2_o, div_signed_o);
      else
        div_result_i = {$urandom, $urandom};
    end
  end

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input string tag);
    logic [2*W-1:0] exp;
    logic [W-1:0] got_hi, got_lo;
    int lat, stalls, we_at, k;
    bit stable_ok, start_ok, idle_ok;
    exp = ref_div(a, b, sgn);
    lat = (b == '0) ? 5 : 37;
    @(negedge clk);
    idle_ok = !busy;
    div_req = 1'b1; op_a_i = a; op_b_i = b;
    div_signed_i = sgn; flush = 1'b0;
    #1;
    stalls = stall_req ? 1 : 0;
    we_at = -1; k = 0; stable_ok = 1; start_ok = 1;
    got_hi = '0; got_lo = '0;
    while (we_at < 0 && k < 60) begin
      @(negedge clk);
      op_a_i = $urandom; op_b_i = $urandom;
      div_signed_i = $urandom_range(0, 1);
      #1;
      k++;
      if (stall_req) stalls++;
      if (hilo_we) begin
        we_at = k; we_cyc = cyc; got_hi = hi_o; got_lo = lo_o;
      end
      if (k <= lat && (div_op1_o !== a || div_op2_o !== b ||
                       div_signed_o !== sgn)) stable_ok = 0;
      if (k < lat && div_start_o !== 1'b1) start_ok = 0;
      if (k == lat && div_start_o !== 1'b0) start_ok = 0;
    end
    checks++;
    if (!idle_ok) begin
      fails++; $display("FAIL %s idle_at_t0: busy got 1 want 0", tag);
    end
    checks++;
    if (we_at != lat) begin
      fails++;
      $display("FAIL %s hilo_we_cycle: got %0d want %0d", tag, we_at, lat);
    end
    checks++;
    if (stalls != lat) begin
      fails++;
      $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, lat);
    end
    checks++;
    if ({got_hi, got_lo} !== exp) begin
      fails++;
      $display("FAIL %s hi_lo: got %h_%h want %h", tag, got_hi, got_lo, exp);
    end
    checks++;
    if (!stable_ok) begin
      fails++; $display("FAIL %s operand_stable: got 0 want 1", tag);
    end
    checks++;
    if (!start_ok) begin
      fails++; $display("FAIL %s start_window: got 0 want 1", tag);
    end
    last_hi = exp[2*W-1:W];
    last_lo = exp[W-1:0];
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    div_req = 1'b0; op_a_i = $urandom; op_b_i = $urandom;
    #1;
    checks++;
    if (hilo_we !== 1'b0 || busy !== 1'b0 || stall_req !== 1'b0) begin
      fails++;
      $display("FAIL %s after_done: we/busy/stall got %b%b%b want 000",
               tag, hilo_we, busy, stall_req);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({div_start_o, div_signed_o, div_annul_o, hilo_we, stall_req, busy,
         div_op1_o, div_op2_o, hi_o, lo_o} !== '0) begin
      fails++;
      $display("FAIL reset_state: got %b%b%b%b%b%b %h %h %h %h want all 0",
               div_start_o, div_signed_o, div_annul_o, hilo_we, stall_req,
               busy, div_op1_o, div_op2_o, hi_o, lo_o);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_neg7_2");
    idle_check("div_neg7_2");
    run_div(32'd100, 32'd7, 1'b0, "divu_100_7");
    idle_check("divu_100_7");
  endtask

  task automatic test_div_zero();
    run_div(32'd12345, 32'd0, 1'b1, "div_by_zero");
    idle_check("div_by_zero");
  endtask

  task automatic test_flush_mid();
    int b_cnt;
    bit ann_ok, we_ok;
    ann_ok = 1; we_ok = 1;
    @(negedge clk);
    div_req = 1'b1; op_a_i = 32'd1000; op_b_i = 32'd7; div_signed_i = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk); #1;
      if (div_annul_o !== 1'b0 || hilo_we !== 1'b0) ann_ok = 0;
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (div_annul_o !== 1'b1 || stall_req !== 1'b1 || !ann_ok) begin
      fails++;
      $display("FAIL flush_mid annul: got %b stall %b early_ok %0d want 1 1 1",
               div_annul_o, stall_req, ann_ok);
    end
    @(negedge clk);
    flush = 1'b0; div_req = 1'b0;
    #1;
    checks++;
    if (div_start_o !== 1'b0 || busy !== 1'b1 || div_annul_o !== 1'b0 ||
        stall_req !== 1'b0) begin
      fails++;
      $display("FAIL flush_mid drain: start/busy/annul/stall %b%b%b%b want 0100",
               div_start_o, busy, div_annul_o, stall_req);
    end
    b_cnt = 1;
    for (int k = 0; k < 10 && busy; k++) begin
      @(negedge clk); #1;
      if (hilo_we) we_ok = 0;
      if (busy) b_cnt++;
    end
    checks++;
    if (b_cnt != DRAIN || !we_ok) begin
      fails++;
      $display("FAIL flush_mid drain_len: got %0d we_ok %0d want %0d 1",
               b_cnt, we_ok, DRAIN);
    end
    run_div(32'd9, 32'd3, 1'b0, "after_flush_9_3");
    idle_check("after_flush_9_3");
  endtask

  task automatic test_flush_ready();
    int k, b_cnt;
    bit we_ok;
    logic [W-1:0] keep_hi, keep_lo;
    keep_hi = last_hi; keep_lo = last_lo; we_ok = 1;
    @(negedge clk);
    div_req = 1'b1; op_a_i = 32'd50; op_b_i = 32'd5; div_signed_i = 1'b0;
    k = 0;
    do begin
      @(negedge clk); #1; k++;
    end while (!div_ready_i && k < 60);
    flush = 1'b1;
    #1;
    checks++;
    if (k != 36 || div_annul_o !== 1'b1) begin
      fails++;
      $display("FAIL flush_ready annul: cycle %0d annul %b want 36 1",
               k, div_annul_o);
    end
    @(negedge clk);
    flush = 1'b0; div_req = 1'b0;
    #1;
    checks++;
    if (hilo_we !== 1'b0 || busy !== 1'b1 || hi_o !== keep_hi ||
        lo_o !== keep_lo) begin
      fails++;
      $display("FAIL flush_ready no_capture: we %b busy %b hi %h lo %h want 0 1 %h %h",
               hilo_we, busy, hi_o, lo_o, keep_hi, keep_lo);
    end
    b_cnt = 1;
    for (int j = 0; j < 10 && busy; j++) begin
      @(negedge clk); #1;
      if (hilo_we) we_ok = 0;
      if (busy) b_cnt++;
    end
    checks++;
    if (b_cnt != DRAIN || !we_ok) begin
      fails++;
      $display("FAIL flush_ready drain_len: got %0d we_ok %0d want %0d 1",
               b_cnt, we_ok, DRAIN);
    end
  endtask

  task automatic test_back_to_back();
    int w1;
    run_div(32'd20, 32'd3, 1'b0, "b2b_20_3");
    w1 = we_cyc;
    run_div(32'd21, 32'd4, 1'b0, "b2b_21_4");
    checks++;
    if (we_cyc - w1 != 38) begin
      fails++;
      $display("FAIL back_to_back spacing: got %0d want 38", we_cyc - w1);
    end
    idle_check("b2b");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic sgn;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      sgn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) b = '0;
      else if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(1, 50));
      else b = $urandom;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      run_div(a, b, sgn, $sformatf("rand%0d", i));
      idle_check($sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    div_req = 1'b1; op_a_i = 32'hFFFF_FF9C; op_b_i = 32'd3;
    div_signed_i = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b0; div_req = 1'b0;
    #1;
    checks++;
    if ({div_start_o, div_signed_o, div_annul_o, hilo_we, stall_req, busy,
         div_op1_o, div_op2_o, hi_o, lo_o} !== '0) begin
      fails++;
      $display("FAIL reset_mid: got %b%b%b%b%b%b %h %h %h %h want all 0",
               div_start_o, div_signed_o, div_annul_o, hilo_we, stall_req,
               busy, div_op1_o, div_op2_o, hi_o, lo_o);
    end
    @(negedge clk);
    rst = 1'b1;
    run_div(32'd77, 32'd10, 1'b0, "after_reset");
    idle_check("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_flush_mid();
    test_flush_ready();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
